// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of an SDRAM controller: port A or B owns the memory
// for one burst read (cache fill) or one halfword write, with round-robin on ties.
module sdram_port_arbiter #(
    parameter int BURSTLEN = 8,
    parameter int ADDRW    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_req,
    input  logic             b_req,
    input  logic             a_rw,
    input  logic             b_rw,
    input  logic [ADDRW-1:0] a_addr,
    input  logic [ADDRW-1:0] b_addr,
    input  logic [15:0]      a_wdata,
    input  logic [15:0]      b_wdata,
    output logic             a_fill,
    output logic             b_fill,
    output logic             a_wack,
    output logic             b_wack,
    output logic [15:0]      rdata,
    output logic             mem_req,
    output logic             mem_rw,
    output logic [ADDRW-1:0] mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic             mem_fill,
    input  logic             mem_wack,
    input  logic [15:0]      mem_rdata,
    output logic             grant,
    output logic             busy
);
    localparam int CW = (BURSTLEN > 1) ? $clog2(BURSTLEN) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BURST, WRDONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            last_grant;
    logic            in_issue;
    logic            sel_req;
    logic            rd_done;
    logic            wr_done;
    logic            next_grant;

    // Outputs are gated by reset so nothing leaks before the first reset edge.
    assign in_issue   = (state == ISSUE) && reset;
    assign sel_req    = grant ? b_req : a_req;
    assign mem_rw     = grant ? b_rw : a_rw;
    assign mem_addr   = grant ? b_addr : a_addr;
    assign mem_wdata  = grant ? b_wdata : a_wdata;
    assign mem_req    = in_issue;
    assign busy       = (state != IDLE) && reset;
    assign rdata      = mem_rdata;

    assign rd_done    = in_issue && mem_rw && mem_fill;
    assign wr_done    = in_issue && !mem_rw && mem_wack;
    assign a_fill     = rd_done && !grant;
    assign b_fill     = rd_done && grant;
    assign a_wack     = wr_done && !grant;
    assign b_wack     = wr_done && grant;

    // Tie goes to whichever port did not win last time.
    assign next_grant = (a_req && b_req) ? !last_grant : b_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rd_done) begin
                        cnt   <= CW'(BURSTLEN - 1);
                        state <= BURST;
                    end else if (wr_done) begin
                        state <= WRDONE;
                    end else if (!sel_req && !mem_fill && !mem_wack) begin
                        state <= IDLE;
                    end
                end
                BURST: begin
                    // The first beat was consumed in ISSUE, so BURST covers the remaining beats.
                    if (cnt <= CW'(1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WRDONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of who owns the memory and for how long.
module tb_sdram_port_arbiter;
    localparam int BL = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_v[2];
    logic        rw_v[2];
    logic [31:0] addr_v[2];
    logic [15:0] wd_v[2];
    logic        mem_fill = 1'b0;
    logic        mem_wack = 1'b0;
    logic [15:0] mem_rdata = 16'h0;

    logic        a_fill, b_fill, a_wack, b_wack, mem_req, mem_rw, grant, busy;
    logic [15:0] rdata, mem_wdata;
    logic [31:0] mem_addr;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt[2] = '{0, 0};

    always #5 clk = ~clk;

    sdram_port_arbiter #(.BURSTLEN(BL), .ADDRW(32)) dut (
        .clk(clk), .reset(reset),
        .a_req(req_v[0]), .b_req(req_v[1]), .a_rw(rw_v[0]), .b_rw(rw_v[1]),
        .a_addr(addr_v[0]), .b_addr(addr_v[1]), .a_wdata(wd_v[0]), .b_wdata(wd_v[1]),
        .a_fill(a_fill), .b_fill(b_fill), .a_wack(a_wack), .b_wack(b_wack),
        .rdata(rdata), .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_fill(mem_fill), .mem_wack(mem_wack),
        .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: owner, whether it is still waiting on the controller,
    // beats of burst left, and whether the one-cycle write tail is pending.
    bit m_started = 0, m_idle = 1, m_wait = 0, m_tail = 0, m_own = 0, m_last = 1;
    int m_beats = 0;

    initial forever begin
        logic rw;
        @(posedge clk);
        m_started = 1;
        rw = rw_v[m_own];
        if (!reset) begin
            m_idle = 1; m_wait = 0; m_tail = 0; m_beats = 0; m_own = 0; m_last = 1;
        end else if (m_idle) begin
            if (req_v[0] || req_v[1]) begin
                m_own  = (req_v[0] && req_v[1]) ? !m_last : req_v[1];
                m_last = m_own;
                m_idle = 0;
                m_wait = 1;
            end
        end else if (m_wait) begin
            if (rw && mem_fill) begin
                m_wait = 0; m_beats = BL - 1;
            end else if (!rw && mem_wack) begin
                m_wait = 0; m_tail = 1;
            end else if (!req_v[m_own] && !mem_fill && !mem_wack) begin
                m_wait = 0; m_idle = 1;
            end
        end else if (m_beats > 0) begin
            m_beats--;
            if (m_beats == 0) m_idle = 1;
        end else begin
            m_tail = 0; m_idle = 1;
        end
    end

    // Compare process: all DUT outputs against the model, every cycle after the first edge.
    initial forever begin
        logic rw, live, e_fill, e_wack;
        logic [71:0] exp_v, act_v;
        @(negedge clk);
        if (m_started) begin
            rw     = rw_v[m_own];
            live   = reset;
            e_fill = live && m_wait && rw && mem_fill;
            e_wack = live && m_wait && !rw && mem_wack;
            exp_v  = {live && !m_idle, live && m_wait, m_own, rw,
                      e_fill && !m_own, e_fill && m_own, e_wack && !m_own, e_wack && m_own,
                      wd_v[m_own], mem_rdata, addr_v[m_own]};
            act_v  = {busy, mem_req, grant, mem_rw, a_fill, b_fill, a_wack, b_wack,
                      mem_wdata, rdata, mem_addr};
            chk("cycle_model", act_v, exp_v);
            if (e_fill || e_wack) done_cnt[m_own]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && busy; i++) tick();
        chk("idle_timeout", 72'(busy), 72'(0));
    endtask

    // Drive one request from idle and answer it after dly ISSUE cycles.
    task automatic serve(input int p, input logic rw, input logic [31:0] addr,
                         input logic [15:0] data, input int dly,
                         output int nb, output int na, output int nbp);
        req_v[p] = 1'b1; rw_v[p] = rw; addr_v[p] = addr; wd_v[p] = data;
        nb = 0; na = 0; nbp = 0;
        tick();
        for (int i = 0; i < 60 && busy; i++) begin
            if (i == dly) begin
                if (rw) mem_fill = 1'b1;
                else    mem_wack = 1'b1;
            end
            #1;
            nb++;
            na  += int'(a_fill | a_wack);
            nbp += int'(b_fill | b_wack);
            if (i == dly)
                chk("serve_fields", 72'({mem_req, mem_rw, grant, mem_wdata, mem_addr}),
                    72'({1'b1, rw, p[0], data, addr}));
            tick();
            mem_fill = 1'b0; mem_wack = 1'b0;
            if (i == dly) req_v[p] = 1'b0;
        end
    endtask

    initial begin
        int nb, na, nbp, k, seen[2];
        logic g[4], f[4];
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; rw_v[p] = 1'b0; addr_v[p] = 32'h0; wd_v[p] = 16'h0;
        end
        repeat (3) tick();
        chk("reset_outputs", 72'({busy, mem_req, a_fill, b_fill, a_wack, b_wack, grant}), 72'(0));
        reset = 1'b1;

        // Read at 0x100, fill on the fourth ISSUE cycle: 3 + 1 + 7 busy cycles.
        serve(0, 1'b1, 32'h100, 16'h0, 3, nb, na, nbp);
        chk("read_busy_cycles", 72'(nb), 72'(11));
        chk("read_fill_pulses", 72'({na, nbp}), 72'({32'd1, 32'd0}));

        // B write of 0xBEEF at 0x2000: ISSUE x3, WRDONE x1.
        serve(1, 1'b0, 32'h2000, 16'hBEEF, 2, nb, na, nbp);
        chk("write_busy_cycles", 72'(nb), 72'(4));
        chk("write_wack_pulses", 72'({na, nbp}), 72'({32'd0, 32'd1}));

        // Both ports hammering reads after a fresh reset: A, B, A, B.
        reset = 1'b0; tick(); reset = 1'b1;
        req_v[0] = 1'b1; rw_v[0] = 1'b1; addr_v[0] = 32'h40;
        req_v[1] = 1'b1; rw_v[1] = 1'b1; addr_v[1] = 32'h80;
        k = 0;
        for (int c = 0; c < 200 && k < 4; c++) begin
            mem_fill = mem_req;
            #1;
            if (a_fill || b_fill) begin
                g[k] = grant; f[k] = b_fill; k++;
            end
            tick();
            mem_fill = 1'b0;
        end
        chk("rr_count", 72'(k), 72'(4));
        for (int i = 0; i < k; i++) chk("rr_order", 72'({g[i], f[i]}), 72'({i[0], i[0]}));
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        wait_idle();

        // Reset two cycles after fill abandons the burst; late fills are ignored.
        req_v[0] = 1'b1; rw_v[0] = 1'b1; addr_v[0] = 32'h300;
        tick();
        mem_fill = 1'b1; tick();
        mem_fill = 1'b0; req_v[0] = 1'b0; tick();
        reset = 1'b0; tick(); reset = 1'b1;
        chk("reset_mid_burst", 72'({busy, mem_req}), 72'(0));
        mem_fill = 1'b1; #1;
        chk("late_fill_ignored", 72'({a_fill, b_fill, busy}), 72'(0));
        tick(); mem_fill = 1'b0;
        serve(0, 1'b1, 32'h500, 16'h0, 1, nb, na, nbp);
        chk("after_reset_read", 72'({nb, na, nbp}), 72'({32'd9, 32'd1, 32'd0}));

        // A abandons its request in ISSUE before any fill.
        req_v[0] = 1'b1; rw_v[0] = 1'b1; addr_v[0] = 32'h700;
        tick(); tick();
        req_v[0] = 1'b0; tick();
        chk("abort_idle", 72'({busy, mem_req}), 72'(0));
        mem_fill = 1'b1; #1;
        chk("abort_no_fill", 72'({a_fill, b_fill}), 72'(0));
        tick(); mem_fill = 1'b0;

        // Random traffic: requesters hold until their own completion pulse, occasionally give up.
        seen[0] = done_cnt[0]; seen[1] = done_cnt[1];
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (req_v[p] && done_cnt[p] != seen[p]) begin
                    req_v[p] = 1'b0;
                end else if (!req_v[p] && $urandom_range(0, 3) == 0) begin
                    req_v[p] = 1'b1; rw_v[p] = 1'($urandom_range(0, 1));
                    addr_v[p] = $urandom; wd_v[p] = 16'($urandom);
                end else if (req_v[p] && $urandom_range(0, 49) == 0) begin
                    req_v[p] = 1'b0;
                end
                seen[p] = done_cnt[p];
            end
            mem_fill  = ($urandom_range(0, 4) == 0);
            mem_wack  = ($urandom_range(0, 4) == 0);
            mem_rdata = 16'($urandom);
            reset     = ($urandom_range(0, 499) != 0);
            tick();
        end
        req_v[0] = 1'b0; req_v[1] = 1'b0; mem_fill = 1'b0; mem_wack = 1'b0; reset = 1'b1;
        wait_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter BURSTLEN, default 8, the number of 16-bit halfwords per read burst; legal values are 2 to 16.
REQ-002 SHALL have parameter ADDRW, default 32, the address width.
REQ-003 SHALL have port: clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port: reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: a_req, b_req  input  1  request from port A or B; held high until fill or ack is seen.
REQ-006 SHALL have ports: a_rw, b_rw  input  1  1 = burst read (cache fill), 0 = single halfword write.
REQ-007 SHALL have ports: a_addr, b_addr  input  ADDRW  request address.
REQ-008 SHALL have ports: a_wdata, b_wdata  input  16  write data.
REQ-009 SHALL have ports: a_fill, b_fill  output  1  one-cycle marker for the first halfword of this port's burst.
REQ-010 SHALL have ports: a_wack, b_wack  output  1  one-cycle write-complete pulse.
REQ-011 SHALL have port: rdata  output  16  shared read data, equal to mem_rdata, to both ports.
REQ-012 SHALL have ports: mem_req, mem_rw  output  1 each  controller request and direction.
REQ-013 SHALL have ports: mem_addr  output  ADDRW, and mem_wdata  output  16.
REQ-014 SHALL have ports: mem_fill  input  1  first cycle of a read burst; data follows on BURSTLEN consecutive cycles starting that cycle.
REQ-015 SHALL have ports: mem_wack  input  1  write accepted; mem_rdata  input  16  read data.
REQ-016 SHALL have ports: grant  output  1  0 = A owns the memory, 1 = B; and busy  output  1  state is not IDLE.

Function
REQ-017 SHALL implement the state machine IDLE, ISSUE, BURST, WRDONE.
REQ-018 In IDLE with exactly one request high, SHALL set grant to that port and go to ISSUE on the next edge.
REQ-019 In IDLE with both requests high, SHALL grant the port not granted last (round-robin); after reset, A wins the first tie.
REQ-020 mem_req SHALL be high only in ISSUE; mem_rw, mem_addr and mem_wdata SHALL be taken from the granted port, combinationally.
REQ-021 In ISSUE with mem_rw=1 and mem_fill=1: SHALL pulse the granted port's fill in the same cycle, load the counter with BURSTLEN-1, and go to BURST.
REQ-022 In BURST: SHALL decrement the counter each cycle and go to IDLE when the counter reaches 1, so BURST occupies exactly BURSTLEN-1 cycles.
REQ-023 In ISSUE with mem_rw=0 and mem_wack=1: SHALL pulse the granted port's wack in the same cycle and go to WRDONE.
REQ-024 WRDONE SHALL last one cycle and then go to IDLE, giving the requester a cycle to drop its request.
REQ-025 SHALL drop mem_req the cycle after mem_fill or mem_wack is seen, because the state has left ISSUE.
REQ-026 If the granted port's request falls while in ISSUE and neither mem_fill nor mem_wack is seen, SHALL abort to IDLE on the next edge with no fill or wack pulse.
REQ-027 Fill and wack SHALL never reach the non-granted port; mem_fill or mem_wack outside ISSUE SHALL be ignored.
REQ-028 The last-grant register SHALL update only on the IDLE-to-ISSUE transition.
REQ-029 A request arriving during ISSUE, BURST or WRDONE SHALL wait; arbitration happens only in IDLE.
REQ-030 Back-to-back service: from IDLE after BURST, a pending request SHALL reach ISSUE on the next edge, so the gap between bursts is at least one cycle.
REQ-031 The counter SHALL be clog2(BURSTLEN) bits wide and SHALL not wrap.

Reset
REQ-032 While reset=0 at an edge: state=IDLE, counter=0, last-grant=B, grant=0.
REQ-033 During reset: mem_req=0, a_fill=b_fill=0, a_wack=b_wack=0, busy=0.
REQ-034 Reset applied mid-burst or mid-write SHALL abandon the transfer; mem_fill or mem_wack arriving afterwards SHALL be ignored.

Verification
REQ-035 A read at 0x100: a_req=1, a_rw=1, a_addr=0x100; mem_fill arrives 3 cycles into ISSUE -> mem_addr=0x100, a_fill high 1 cycle, busy high for 3+1+7 cycles, then IDLE.
REQ-036 Simultaneous requests after reset, both reads -> A served first, B granted at the first IDLE after A's burst ends, b_fill only on B's burst.
REQ-037 B write of 0xBEEF at 0x2000 -> mem_rw=0, mem_wdata=0xBEEF, b_wack high in the same cycle as mem_wack, WRDONE for 1 cycle, a_wack stays 0.
REQ-038 Reset pulsed 2 cycles after mem_fill -> state IDLE, mem_req=0; no further fill, and a new A request is granted normally.
REQ-039 A drops its request in ISSUE before mem_fill -> IDLE next cycle, no a_fill; a later mem_fill pulse produces no fill on either port.
REQ-040 Both ports requesting continuously for 4 transactions -> grant alternates A, B, A, B.
